// File: rtl/posit_pkg.sv
// Shared constants, helpers and stage payload for the posit encode pipeline.
// The payload struct is sized from P_N/P_ES, so the pipeline parameters must match them.
package posit_pkg;

    localparam int P_N   = 32;
    localparam int P_ES  = 2;
    localparam int P_RS  = $clog2(P_N);
    localparam int BW    = 2 * P_N + P_ES;
    localparam int LEN_W = P_RS + 2;

    localparam logic [P_N-1:0] NAR = {1'b1, {(P_N-1){1'b0}}};

    function automatic logic [P_N-1:0] maxpos();
        return {1'b0, {(P_N-1){1'b1}}};
    endfunction

    function automatic logic [P_N-1:0] minpos();
        return {{(P_N-1){1'b0}}, 1'b1};
    endfunction

    // Number of regime bits including the terminating bit.
    function automatic logic [LEN_W-1:0] regimeLen(input logic signed [P_RS:0] k);
        logic signed [LEN_W-1:0] kx;
        kx = LEN_W'(k);
        return k[P_RS] ? LEN_W'(1 - kx) : LEN_W'(kx + 2);
    endfunction

    typedef struct packed {
        logic          sign;
        logic          inf;
        logic          zero;
        logic [BW-1:0] body;
    } stage_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of the unsigned posit body down to N-1 magnitude bits,
// clamped so a nonzero value never becomes zero or wraps into NaR.
module posit_round_rne
    import posit_pkg::*;
(
    input  logic [BW-1:0]  i_body,
    output logic [P_N-2:0] o_mag
);

    localparam logic [P_N-1:0] MAXPOS = maxpos();
    localparam logic [P_N-1:0] MINPOS = minpos();

    logic [P_N-2:0] w_mag;
    logic           w_guard;
    logic           w_sticky;
    logic           w_roundUp;
    logic [P_N-1:0] w_sum;

    assign w_mag     = i_body[BW-1 -: P_N-1];
    assign w_guard   = i_body[BW-P_N];
    assign w_sticky  = |i_body[BW-P_N-1:0];
    assign w_roundUp = w_guard & (w_mag[0] | w_sticky);
    assign w_sum     = {1'b0, w_mag} + {{(P_N-1){1'b0}}, w_roundUp};

    // Saturated regimes land here too: an all-ones carry means maxpos, an empty magnitude means minpos.
    always_comb begin
        o_mag = w_sum[P_N-2:0];
        if (w_sum[P_N-1]) begin
            o_mag = MAXPOS[P_N-2:0];
        end else if (w_sum[P_N-2:0] == '0) begin
            o_mag = MINPOS[P_N-2:0];
        end
    end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Three-stage posit packer: build body, round, then apply specials and sign.
// Valid/ready chain with bubble collapse; the stage registers are the only storage.
module posit_encoder_pipe
    import posit_pkg::*;
#(
    parameter int N  = P_N,
    parameter int ES = P_ES,
    parameter int RS = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sign_i,
    input  logic signed [RS:0]  k_i,
    input  logic [ES-1:0]       exp_i,
    input  logic [N-1:0]        frac_i,
    input  logic                sticky_i,
    input  logic                inf_i,
    input  logic                zero_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_posit
);

    localparam int TW = 1 + ES + N;

    logic [LEN_W-1:0] w_shift;
    logic             w_fill;
    logic [TW-1:0]    w_tail;
    logic [2*BW-1:0]  w_wide;
    stage_t           w_s1Next;
    logic [N-2:0]     w_s2Mag;
    logic [N-1:0]     w_s3Next;
    logic             w_s1Free;
    logic             w_s2Free;
    logic             w_s3Free;

    stage_t           r_s1;
    logic             r_v1;
    logic             r_s2Sign;
    logic             r_s2Inf;
    logic             r_s2Zero;
    logic [N-2:0]     r_s2Mag;
    logic             r_v2;
    logic [N-1:0]     r_posit;
    logic             r_v3;

    assign w_s3Free = !r_v3 | out_ready;
    assign w_s2Free = !r_v2 | w_s3Free;
    assign w_s1Free = !r_v1 | w_s2Free;
    assign in_ready  = w_s1Free;
    assign out_valid = r_v3;
    assign out_posit = r_posit;

    // The regime fill bit shifts in from the top; the terminator leads the exp/frac tail.
    assign w_fill  = ~k_i[RS];
    assign w_shift = regimeLen(k_i) - LEN_W'(1);
    assign w_tail  = {~w_fill, exp_i, frac_i};
    assign w_wide  = {{BW{w_fill}}, w_tail, {(BW-TW){1'b0}}} >> w_shift;

    // sticky_i folds into the lowest body bit, which only ever feeds the sticky OR.
    always_comb begin
        w_s1Next      = '0;
        w_s1Next.sign = sign_i;
        w_s1Next.inf  = inf_i;
        w_s1Next.zero = zero_i;
        w_s1Next.body = w_wide[BW-1:0] | {{(BW-1){1'b0}}, sticky_i};
    end

    posit_round_rne u_round (
        .i_body (r_s1.body),
        .o_mag  (w_s2Mag)
    );

    always_comb begin
        w_s3Next = {1'b0, r_s2Mag};
        if (r_s2Inf) begin
            w_s3Next = NAR;
        end else if (r_s2Zero) begin
            w_s3Next = '0;
        end else if (r_s2Sign) begin
            w_s3Next = -{1'b0, r_s2Mag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_s1     <= '0;
            r_s2Sign <= 1'b0;
            r_s2Inf  <= 1'b0;
            r_s2Zero <= 1'b0;
            r_s2Mag  <= '0;
            r_posit  <= '0;
        end else begin
            if (w_s1Free) begin
                r_v1 <= in_valid;
            end
            if (w_s1Free && in_valid) begin
                r_s1 <= w_s1Next;
            end
            if (w_s2Free) begin
                r_v2 <= r_v1;
            end
            if (w_s2Free && r_v1) begin
                r_s2Sign <= r_s1.sign;
                r_s2Inf  <= r_s1.inf;
                r_s2Zero <= r_s1.zero;
                r_s2Mag  <= w_s2Mag;
            end
            if (w_s3Free) begin
                r_v3 <= r_v2;
            end
            if (w_s3Free && r_v2) begin
                r_posit <= w_s3Next;
            end
        end
    end

endmodule
